// File: rtl/vga_gen_if.sv
// Video pin bundle between the timing generator and the LCD/DAC.
// The master drives every signal; the slave only observes.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (
    output CLK, HS, VS, BLANK, RGB
  );

  modport slave (
    input CLK, HS, VS, BLANK, RGB
  );
endinterface

// File: rtl/vga_gen.sv
// VGA/LCD timing generator with grid, bars, stream and solid sources.
// All video outputs are registered one clock after the counters.
module vga_gen #(
  parameter int HDISP     = 800,
  parameter int VDISP     = 480,
  parameter int HFP       = 40,
  parameter int HPULSE    = 48,
  parameter int HBP       = 40,
  parameter int VFP       = 13,
  parameter int VPULSE    = 3,
  parameter int VBP       = 29,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int GRID_LOG2 = 4
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        underflow_clr,
  output logic        underflow,
  output logic        frame_start,
  video_if.master     video_ifm
);

  localparam int HB   = HFP + HPULSE + HBP;
  localparam int VB   = VFP + VPULSE + VBP;
  localparam int HTOT = HB + HDISP;
  localparam int VTOT = VB + VDISP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);

  localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);
  localparam logic [HW-1:0] H_SS   = HW'(HFP);
  localparam logic [HW-1:0] H_SE   = HW'(HFP + HPULSE);
  localparam logic [VW-1:0] V_SS   = VW'(VFP);
  localparam logic [VW-1:0] V_SE   = VW'(VFP + VPULSE);
  localparam logic [HW-1:0] H_B    = HW'(HB);
  localparam logic [VW-1:0] V_B    = VW'(VB);

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic [1:0]    mode_q;

  logic          hs_c;
  logic          vs_c;
  logic          act;
  logic          first;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic [HW+2:0] x8;
  logic [2:0]    bar;
  logic [23:0]   bar_rgb;
  logic [23:0]   grid_rgb;
  logic [23:0]   src_rgb;

  logic          hs_q;
  logic          vs_q;
  logic          blank_q;
  logic [23:0]   rgb_q;

  // Raster counters; reset restarts the frame at the next edge.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
    end else begin
      hc <= hc + HW'(1);
    end
  end

  // Source select is sampled only at the frame origin.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst)
      mode_q <= 2'd0;
    else if (hc == '0 && vc == '0)
      mode_q <= mode;
  end

  assign hs_c  = (hc >= H_SS) && (hc < H_SE);
  assign vs_c  = (vc >= V_SS) && (vc < V_SE);
  assign act   = (hc >= H_B) && (vc >= V_B);
  assign x     = hc - H_B;
  assign y     = vc - V_B;
  assign first = act && (x == '0) && (y == '0);
  assign x8    = {x, 3'b000};

  assign pix_ready = act && (mode_q == 2'd2) && !pixel_rst;

  assign grid_rgb =
    (x[GRID_LOG2-1:0] == '0 || y[GRID_LOG2-1:0] == '0)
      ? 24'hFFFFFF : 24'h000000;

  // Bar index via comparator chain: highest k with 8x >= k*HDISP.
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (x8 >= (HW+3)'(k * HDISP))
        bar = 3'(k);
  end

  // Bar colour table.
  always_comb begin
    case (bar)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // Pixel source mux; a missing stream beat shows as black.
  always_comb begin
    unique case (mode_q)
      2'd0: src_rgb = grid_rgb;
      2'd1: src_rgb = bar_rgb;
      2'd2: src_rgb = pix_valid ? pix_data : 24'h000000;
      2'd3: src_rgb = solid_rgb;
    endcase
  end

  // Registered video outputs, all aligned one clock behind counters.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      hs_q        <= !HS_POL;
      vs_q        <= !VS_POL;
      blank_q     <= 1'b0;
      rgb_q       <= 24'h000000;
      frame_start <= 1'b0;
    end else begin
      hs_q        <= hs_c ? HS_POL : !HS_POL;
      vs_q        <= vs_c ? VS_POL : !VS_POL;
      blank_q     <= act;
      rgb_q       <= act ? src_rgb : 24'h000000;
      frame_start <= first;
    end
  end

  // Sticky underflow; a new set beats a simultaneous clear.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst)
      underflow <= 1'b0;
    else if (pix_ready && !pix_valid)
      underflow <= 1'b1;
    else if (underflow_clr)
      underflow <= 1'b0;
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_q;
  assign video_ifm.VS    = vs_q;
  assign video_ifm.BLANK = blank_q;
  assign video_ifm.RGB   = rgb_q;

endmodule

// File: tb/tb_vga_gen.sv
// Bench for vga_gen on a tiny 14x7 raster.
// A frame-position model predicts every output each cycle.
module tb_vga_gen;

  localparam int HDISP  = 8;
  localparam int VDISP  = 4;
  localparam int HFP    = 2;
  localparam int HPULSE = 3;
  localparam int HBP    = 1;
  localparam int VFP    = 1;
  localparam int VPULSE = 1;
  localparam int VBP    = 1;
  localparam int GRID   = 4;
  localparam int HB     = HFP + HPULSE + HBP;
  localparam int VB     = VFP + VPULSE + VBP;
  localparam int HTOT   = HB + HDISP;
  localparam int VTOT   = VB + VDISP;
  localparam int FRAME  = HTOT * VTOT;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [23:0] solid;
  logic [23:0] pdata;
  logic        pvalid;
  logic        uclr;
  logic        pready;
  logic        uf;
  logic        fs;

  video_if vif ();

  vga_gen #(
    .HDISP(HDISP), .VDISP(VDISP),
    .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .GRID_LOG2(2)
  ) dut (
    .pixel_clk(clk),
    .pixel_rst(rst),
    .mode(mode),
    .solid_rgb(solid),
    .pix_data(pdata),
    .pix_valid(pvalid),
    .pix_ready(pready),
    .underflow_clr(uclr),
    .underflow(uf),
    .frame_start(fs),
    .video_ifm(vif)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int          pos = 0;
  int          mq  = 0;
  bit          m_uf, m_hs, m_vs, m_bl, m_fs;
  logic [23:0] m_rgb;

  int cyc       = 0;
  int ready_cnt = 0;
  int fs_last   = -1;
  int fs_prev   = -1;
  bit auto_inc  = 0;

  function automatic logic [23:0] bar_col(int b);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic chk(string tag, logic [23:0] obs, logic [23:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h",
             tag, cyc, obs, exp);
    end
  endtask

  // One clock: predict from frame position, then compare.
  task automatic step();
    int h, v, x, y;
    bit act, pr;
    logic [23:0] px;
    h   = pos % HTOT;
    v   = pos / HTOT;
    act = (h >= HB) && (v >= VB);
    x   = h - HB;
    y   = v - VB;
    pr  = !rst && act && (mq == 2);
    chk("pix_ready", {23'd0, pready}, {23'd0, pr});
    case (mq)
      0: px = ((x % GRID == 0) || (y % GRID == 0))
              ? 24'hFFFFFF : 24'h000000;
      1: px = bar_col((x * 8) / HDISP);
      2: px = pvalid ? pdata : 24'h000000;
      default: px = solid;
    endcase
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      pos   = 0;
      mq    = 0;
      m_uf  = 0;
      m_hs  = 1;
      m_vs  = 1;
      m_bl  = 0;
      m_rgb = 0;
      m_fs  = 0;
    end else begin
      m_hs  = !(h >= HFP && h < HFP + HPULSE);
      m_vs  = !(v >= VFP && v < VFP + VPULSE);
      m_bl  = act;
      m_rgb = act ? px : 24'h000000;
      m_fs  = act && x == 0 && y == 0;
      if (pr && !pvalid) m_uf = 1;
      else if (uclr)     m_uf = 0;
      if (pos == 0) mq = mode;
      pos = (pos + 1) % FRAME;
    end
    chk("hs",    {23'd0, vif.HS},    {23'd0, m_hs});
    chk("vs",    {23'd0, vif.VS},    {23'd0, m_vs});
    chk("blank", {23'd0, vif.BLANK}, {23'd0, m_bl});
    chk("rgb",   vif.RGB,            m_rgb);
    chk("fs",    {23'd0, fs},        {23'd0, m_fs});
    chk("uflow", {23'd0, uf},        {23'd0, m_uf});
    if (pr) ready_cnt++;
    if (fs) begin
      fs_prev = fs_last;
      fs_last = cyc;
    end
    if (auto_inc && pr && pvalid) pdata = pdata + 24'd1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(int p);
    for (int i = 0; i < FRAME && pos != p; i++) step();
  endtask

  initial begin
    int lat;
    int p;
    rst    = 1;
    mode   = 2'd3;
    solid  = 24'h123456;
    pdata  = 0;
    pvalid = 0;
    uclr   = 0;

    run(3);
    chk("rst_hs",    {23'd0, vif.HS},    24'd1);
    chk("rst_blank", {23'd0, vif.BLANK}, 24'd0);

    rst = 0;
    run(2 * FRAME + 5);
    chk("fs_period", 24'(fs_last - fs_prev), 24'(FRAME));
    solid = 24'($urandom);
    run(FRAME);

    mode = 2'd0;
    run(2 * FRAME);

    mode = 2'd2;
    pvalid = 1;
    run_to(0);
    step();
    run_to(0);
    pdata     = 0;
    auto_inc  = 1;
    ready_cnt = 0;
    run(FRAME);
    chk("ready_per_frame", 24'(ready_cnt), 24'(HDISP * VDISP));
    chk("stream_count",    pdata,          24'(HDISP * VDISP));

    p = (VB + 1) * HTOT + HB + 3;
    run_to(p);
    pvalid = 0;
    step();
    pvalid = 1;
    run(5);
    chk("uf_sticky", {23'd0, uf}, 24'd1);
    uclr = 1;
    step();
    uclr = 0;
    run(3);
    run_to(p);
    pvalid = 0;
    uclr   = 1;
    step();
    pvalid = 1;
    uclr   = 0;
    chk("uf_set_wins", {23'd0, uf}, 24'd1);
    auto_inc = 0;
    for (int i = 0; i < FRAME; i++) begin
      pvalid = ($urandom % 4) != 0;
      uclr   = ($urandom % 8) == 0;
      pdata  = 24'($urandom);
      step();
    end
    pvalid = 1;
    uclr   = 0;

    mode = 2'd0;
    run_to(0);
    step();
    run_to((VB + 2) * HTOT);
    mode = 2'd1;
    run(FRAME + HTOT);

    for (int f = 0; f < 4; f++) begin
      mode  = 2'($urandom);
      solid = 24'($urandom);
      for (int i = 0; i < FRAME; i++) begin
        pvalid = ($urandom % 3) != 0;
        pdata  = 24'($urandom);
        uclr   = ($urandom % 16) == 0;
        step();
      end
    end
    pvalid = 1;
    uclr   = 0;

    run_to(4 * HTOT + 9);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_rgb", vif.RGB, 24'd0);
    chk("mid_rst_vs",  {23'd0, vif.VS}, 24'd1);
    lat = 0;
    for (int i = 0; i < 2 * FRAME && !fs; i++) begin
      step();
      lat++;
    end
    chk("rst_to_fs", 24'(lat), 24'(VB * HTOT + HB + 1));
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
